cache_arbiter: RTL
==================

# cache_arbiter

Two-port arbiter that shares the single cache controller port between an instruction-fetch requester (port 0) and a data load/store requester (port 1). Each requester issues one word transaction at a time with a req/ack handshake. The arbiter selects one requester, drives the controller's addr/wdata/rd/wr, holds them until the controller signals completion, and returns read data and ack to the owner.

## Interface
- AW, 30: word-address width (matches controller addr).
- DW, 32: data width.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  transaction request; held high with fields stable until the matching ack.
- m0_wr, m1_wr  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  AW  word address.
- m0_wdata, m1_wdata  in  DW  write data (ignored for reads).
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_rdata, m1_rdata  out  DW  read data, valid only in the ack cycle.
- c_addr  out  AW  controller address.
- c_wdata  out  DW  controller write data.
- c_rd, c_wr  out  1  controller strobes; at most one high.
- c_done  in  1  controller completion (hit after any writeback/refill).
- c_rdata  in  DW  controller read data, valid with c_done.
- owner  out  1  current/last granted port (debug).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any req, choose a winner per arbitration policy and register c_addr/c_wdata/c_rd/c_wr from it. Set owner and go to BUSY. Otherwise stay in IDLE with c_rd = c_wr = 0.
- BUSY: hold c_* stable. When c_done = 1: capture c_rdata into the owner's rdata register, drop c_rd/c_wr, and go to RESP.
- RESP: the owner's ack is high for exactly this cycle; the non-owner's ack and rdata stay 0. Next state is IDLE unconditionally. req is not sampled in RESP, so a requester may hold req high to chain a new transaction.
- Write transactions still return ack. rdata on a write ack is 0.
- Arbitration always uses only the reqs sampled in IDLE. A req rising while BUSY waits.
- A req that drops before its ack is a protocol violation. The arbiter does not abort. It completes the transaction and pulses ack anyway.
- c_rd and c_wr are never both 1. c_wr = owner's wr, and c_rd = not wr.

## Timing
- Reset values: all acks 0, all rdata 0, c_rd = c_wr = 0, c_addr = 0, c_wdata = 0, owner = 1 (so port 0 wins the first contention), state IDLE.
- req sampled in IDLE at edge t drives c_rd/c_wr high from t+1.
- c_done sampled at edge d makes ack high during cycle d+1 (RESP). The arbiter is in IDLE at d+2, so the next transaction's strobe rises at d+3.
- Minimum issue-to-issue spacing is 3 cycles plus the controller latency.
- c_done while IDLE or RESP is ignored.
- Reset asserted mid-transaction clears everything immediately (asynchronously). No ack is produced for the abandoned transaction. The controller shares rst and is cleared too.

## Configuration
- ARB_RR_EN defined: round-robin. On contention in IDLE, the port not equal to owner wins. With a single requester, that requester wins.
- ARB_RR_EN undefined: fixed priority. Port 0 wins every contention, port 1 proceeds only when m0_req = 0 in IDLE, and owner is still updated.

## Test plan
- Reset release, m0 read addr 0x10, controller c_done 4 cycles after strobe with c_rdata 0xDEADBEEF -> m0_ack for one cycle with m0_rdata 0xDEADBEEF; m1_ack = 0.
- m1 write addr 0x20, data 0x12345678 -> c_wr = 1, c_rd = 0, c_addr 0x20, c_wdata 0x12345678 held until c_done; m1_ack pulses with m1_rdata 0.
- Both req high continuously, ARB_RR_EN defined -> grants alternate 0,1,0,1. Undefined -> port 0 is granted every time and m1 never acks.
- m1_req rises while m0 is BUSY -> c_addr does not change; m1 is granted in the first IDLE after m0's ack.
- rst pulsed while BUSY -> c_rd/c_wr go to 0 immediately, no ack is produced, and after release the FSM is in IDLE with owner = 1.
- Spurious c_done in IDLE -> no ack and no state change.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one cache controller port between an instruction-fetch
// requester (port 0) and a data load/store requester (port 1).
// Each transaction is one word with a req/ack handshake.
//
// Optional feature macro: ARB_RR_EN
//   - Defined: round-robin arbitration.
//   - Undefined (default): fixed priority, with port 0 always winning.
module cache_arbiter #(
    parameter int AW = 30,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] c_addr,
    output logic [DW-1:0] c_wdata,
    output logic          c_rd,
    output logic          c_wr,
    input  logic          c_done,
    input  logic [DW-1:0] c_rdata,
    output logic          owner
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic          any_req;
    logic          grant;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Pick the winning port from the reqs seen this cycle and mux its fields
    always_comb begin
        any_req = m0_req | m1_req;
`ifdef ARB_RR_EN
        if (m0_req && m1_req) begin
            grant = ~owner;
        end else begin
            grant = ~m0_req;
        end
`else
        grant = ~m0_req;
`endif
        sel_wr    = grant ? m1_wr    : m0_wr;
        sel_addr  = grant ? m1_addr  : m0_addr;
        sel_wdata = grant ? m1_wdata : m0_wdata;
    end

    // Arbiter FSM: every output is registered, and acks/rdata are single-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= 1'b1;
            c_addr   <= '0;
            c_wdata  <= '0;
            c_rd     <= 1'b0;
            c_wr     <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= grant;
                        c_addr  <= sel_addr;
                        c_wdata <= sel_wdata;
                        c_wr    <= sel_wr;
                        c_rd    <= ~sel_wr;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (c_done) begin
                        c_rd  <= 1'b0;
                        c_wr  <= 1'b0;
                        state <= RESP;
                        if (owner) begin
                            m1_ack   <= 1'b1;
                            m1_rdata <= c_wr ? '0 : c_rdata;
                        end else begin
                            m0_ack   <= 1'b1;
                            m0_rdata <= c_wr ? '0 : c_rdata;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
